// File: rtl/fetch_controller.sv
// Fetch stage controller: boot-loads the byte-wide instruction memory, then fetches into IF/ID.
// Optional macro FETCH_FLUSH_EN squashes the word fetched alongside a taken branch.
//
// state  | meaning
// S_LOAD | accepting boot bytes, writing them through the memory write port
// S_RUN  | fetching at pc, handling stall, branch redirect and range faults
// S_HALT | fetch fault taken; everything frozen until reset
module fetch_controller #(
  parameter int unsigned MEM_BYTES = 116,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [7:0]  mem_wdata_o,
  output logic [31:0] pc_o,
  input  logic [31:0] instr_in_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        if_id_valid_o,
  output logic        fetch_fault_o
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [31:0] LAST_FETCH = 32'(MEM_BYTES - 4);
  localparam logic [31:0] LAST_BYTE  = 32'(MEM_BYTES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] pc_plus4;
  logic        fetch_legal;

  // A wrapped pc+4 lands near zero only from the top of the space, where the range check rejects it.
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_FETCH);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_LOAD;
      pc_q    <= RESET_PC;
      count_q <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    load_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    mem_waddr_o  = count_q;
    mem_wdata_o  = load_byte_i;

    case (state_q)
      S_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          mem_we_o = 1'b1;
          count_d  = count_q + 32'd1;
          if (load_last_i || (count_q == LAST_BYTE)) begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (!stall_i && !fetch_legal) begin
          state_d = S_HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else begin
          if (!stall_i) begin
            instr_d = instr_in_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
`ifdef FETCH_FLUSH_EN
            if (branch_taken_i) begin
              instr_d = '0;
              valid_d = 1'b0;
            end
`endif
          end
          // Redirect wins even under stall so the target is not lost.
          if (branch_taken_i) begin
            pc_d = branch_target_i;
          end else if (!stall_i) begin
            pc_d = pc_plus4;
          end
        end
      end

      S_HALT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign fetch_fault_o = fault_q;

endmodule
